oflow_conflict_resolve: RTL

//  Read-side / pointer-writer partner of the score board. After registration fills the board, this block

---
 rtl/oflow_conflict_resolve.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/oflow_conflict_resolve.sv
// Duplicate-ID resolver: scans score-board row pairs and flips the losing row's pointer.
// Optional OFLOW_CR_STATS_EN adds saturating conflict_cnt / pass_cnt outputs.
module oflow_conflict_resolve #(
    parameter int unsigned MAX_ROWS   = 32,
    parameter int unsigned ROW_LEN    = 5,
    parameter int unsigned ID_LEN     = 12,
    parameter int unsigned SCORE_LEN  = 16,
    parameter int unsigned MAX_PASSES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ready_new_frame,
    input  logic                 start_cr,
    input  logic [ROW_LEN:0]     num_rows,
    output logic                 done_cr,
    output logic                 unresolved,
    output logic [ROW_LEN-1:0]   row_sel_from_cr,
    input  logic [SCORE_LEN-1:0] score_to_cr,
    input  logic [ID_LEN-1:0]    id_to_cr,
    output logic                 write_to_pointer,
    output logic [ROW_LEN-1:0]   row_to_change,
`ifdef OFLOW_CR_STATS_EN
    output logic [ROW_LEN:0]     conflict_cnt,
    output logic [2:0]           pass_cnt,
`endif
    output logic                 data_from_cr
);
    localparam int unsigned PassW = $clog2(MAX_PASSES + 1);

    typedef enum logic [2:0] {StIdle, StLoadI, StScanJ, StWrite, StEndPass, StDone} state_e;

    state_e                 state_q, state_d;
    logic [ROW_LEN-1:0]     i_q, i_d, j_q, j_d, row_q, row_d;
    logic [ROW_LEN:0]       n_q, n_d;
    logic [PassW-1:0]       pass_q, pass_d;
    logic [MAX_ROWS-1:0]    flipped_q, flipped_d;
    logic                   pconf_q, pconf_d, loser_i_q, loser_i_d;
    logic [ID_LEN-1:0]      id_i_q, id_i_d;
    logic [SCORE_LEN-1:0]   score_i_q, score_i_d;
    logic                   done_q, done_d, wr_q, wr_d, unres_q, unres_d;

    logic                   conflict, lose_i, advance, last_j, more_i;
    logic [ROW_LEN-1:0]     loser;
    logic [PassW-1:0]       pass_nx;

    assign conflict = (id_to_cr == id_i_q) && (id_i_q != '0);
    // Tie on score makes j (the higher index) the loser.
    assign lose_i   = score_i_q > score_to_cr;
    assign loser    = lose_i ? i_q : j_q;
    assign last_j   = ({1'b0, j_q} + (ROW_LEN+1)'(1)) == n_q;
    assign more_i   = ({1'b0, i_q} + (ROW_LEN+1)'(2)) < n_q;
    assign pass_nx  = pass_q + PassW'(1);

    always_comb begin
        row_sel_from_cr = '0;
        case (state_q)
            StLoadI: row_sel_from_cr = i_q;
            StScanJ: row_sel_from_cr = j_q;
            default: row_sel_from_cr = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        n_d       = n_q;
        pass_d    = pass_q;
        flipped_d = flipped_q;
        pconf_d   = pconf_q;
        loser_i_d = loser_i_q;
        id_i_d    = id_i_q;
        score_i_d = score_i_q;
        done_d    = 1'b0;
        wr_d      = 1'b0;
        row_d     = row_q;
        unres_d   = unres_q;
        advance   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_cr) begin
                    n_d       = num_rows;
                    flipped_d = '0;
                    unres_d   = 1'b0;
                    pass_d    = '0;
                    pconf_d   = 1'b0;
                    i_d       = '0;
                    state_d   = (num_rows < (ROW_LEN+1)'(2)) ? StDone : StLoadI;
                end
            end
            StLoadI: begin
                id_i_d    = id_to_cr;
                score_i_d = score_to_cr;
                j_d       = i_q + ROW_LEN'(1);
                state_d   = StScanJ;
            end
            StScanJ: begin
                if (conflict && !flipped_q[loser]) begin
                    wr_d             = 1'b1;
                    row_d            = loser;
                    flipped_d[loser] = 1'b1;
                    pconf_d          = 1'b1;
                    loser_i_d        = lose_i;
                    state_d          = StWrite;
                end else begin
                    if (conflict) unres_d = 1'b1;
                    advance = 1'b1;
                end
            end
            StWrite: begin
                // A flipped row i makes id_i stale, so it must be reloaded.
                if (loser_i_q) state_d = StLoadI;
                else           advance = 1'b1;
            end
            StEndPass: begin
                pass_d = pass_nx;
                if (pconf_q && (pass_nx < PassW'(MAX_PASSES))) begin
                    pconf_d = 1'b0;
                    i_d     = '0;
                    state_d = StLoadI;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (advance) begin
            if (!last_j) begin
                j_d = j_q + ROW_LEN'(1);
            end else if (more_i) begin
                i_d     = i_q + ROW_LEN'(1);
                state_d = StLoadI;
            end else begin
                state_d = StEndPass;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || ready_new_frame) begin
            state_q   <= StIdle;
            i_q       <= '0;
            j_q       <= '0;
            n_q       <= '0;
            pass_q    <= '0;
            flipped_q <= '0;
            pconf_q   <= 1'b0;
            loser_i_q <= 1'b0;
            id_i_q    <= '0;
            score_i_q <= '0;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
            row_q     <= '0;
            unres_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            n_q       <= n_d;
            pass_q    <= pass_d;
            flipped_q <= flipped_d;
            pconf_q   <= pconf_d;
            loser_i_q <= loser_i_d;
            id_i_q    <= id_i_d;
            score_i_q <= score_i_d;
            done_q    <= done_d;
            wr_q      <= wr_d;
            row_q     <= row_d;
            unres_q   <= unres_d;
        end
    end

    assign done_cr          = done_q;
    assign write_to_pointer = wr_q;
    assign row_to_change    = row_q;
    assign unresolved       = unres_q;
    assign data_from_cr     = 1'b1;

`ifdef OFLOW_CR_STATS_EN
    logic [ROW_LEN:0] ccnt_q, ccnt_d;
    logic [2:0]       pcnt_q, pcnt_d;

    always_comb begin
        ccnt_d = ccnt_q;
        pcnt_d = pcnt_q;
        if (state_q == StIdle && start_cr) begin
            ccnt_d = '0;
            pcnt_d = '0;
        end else begin
            if (wr_d && ccnt_q != '1)                  ccnt_d = ccnt_q + (ROW_LEN+1)'(1);
            if (state_q == StEndPass && pcnt_q != '1) pcnt_d = pcnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || ready_new_frame) begin
            ccnt_q <= '0;
            pcnt_q <= '0;
        end else begin
            ccnt_q <= ccnt_d;
            pcnt_q <= pcnt_d;
        end
    end

    assign conflict_cnt = ccnt_q;
    assign pass_cnt     = pcnt_q;
`endif
endmodule
